// File: rtl/kw_pipe_credit_ctrl.sv
// kw_pipe_credit_ctrl: credit-gated valid/ready wrapper around a fixed-latency, non-stallable pipeline.
// In-flight beats are tracked by a valid shift register and land in an in-order skid buffer.
module kw_pipe_credit_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2,
    parameter int BUF_DEPTH  = 4,
    localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] pipe_a,
    input  logic [DATA_WIDTH-1:0] pipe_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         credits,
    output logic                  busy
);
    localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;

    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [DEPTH:0]        vld_sh;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d, credits_q, credits_d;
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic                  issue, pop, wr;

    // Pointers wrap explicitly so BUF_DEPTH need not be a power of two.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = credits_q != '0;
    assign issue     = in_valid & in_ready;
    assign out_valid = count_q != '0;
    assign pop       = out_valid & out_ready;
    assign wr        = vld_q[DEPTH-1];
    assign pipe_a    = issue ? in_data : '0;
    assign out_data  = mem_q[rptr_q];
    assign credits   = credits_q;
    assign busy      = (|vld_q) | out_valid;

    always_comb begin
        vld_sh    = {vld_q, issue};
        vld_d     = vld_sh[DEPTH-1:0];
        wptr_d    = wr ? inc(wptr_q) : wptr_q;
        rptr_d    = pop ? inc(rptr_q) : rptr_q;
        count_d   = count_q + CW'(wr) - CW'(pop);
        credits_d = credits_q - CW'(issue) + CW'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            credits_q <= CW'(BUF_DEPTH);
        end else begin
            vld_q     <= vld_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
        end
    end

    // Payload storage is left unreset; out_data is only meaningful while out_valid.
    always_ff @(posedge clock) begin
        if (wr) mem_q[wptr_q] <= pipe_b;
    end
endmodule
